// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio-path constants and sample-pair type
package audio_pkg;

    // Default channel geometry: 24-bit samples in 32-bit slots, 50 MHz / 16 BCLK.
    localparam int AUD_DATA_W    = 24;
    localparam int AUD_SLOT_W    = 32;
    localparam int AUD_BCLK_HALF = 8;

    // Word-clock levels: left channel while low, right channel while high.
    localparam logic LRCK_LEFT  = 1'b0;
    localparam logic LRCK_RIGHT = 1'b1;

    // Stereo pair at the default width, as produced by the tone/sample sources.
    typedef struct packed {
        logic signed [AUD_DATA_W-1:0] left;
        logic signed [AUD_DATA_W-1:0] right;
    } sample_pair_t;

endpackage

// File: rtl/i2s_bclk_gen.sv
// rtl/i2s_bclk_gen.sv - bit-clock divider with falling-edge strobe
module i2s_bclk_gen
    import audio_pkg::*;
#(
    parameter int BCLK_HALF = AUD_BCLK_HALF
) (
    input  logic clk,
    input  logic resetn,
    input  logic enable,
    output logic bclk,
    output logic fall_evt
);
    localparam int CW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

    logic [CW-1:0] cnt;
    logic          tc;

    assign tc       = (cnt == CW'(BCLK_HALF - 1));
    // The strobe coincides with the clk edge on which bclk drops, so the
    // frame logic can update its registers in lock-step with the fall.
    assign fall_evt = enable && tc && bclk;

    // Half-period counter; bclk toggles at terminal count, idles low when disabled.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt  <= '0;
            bclk <= 1'b0;
        end else if (!enable) begin
            cnt  <= '0;
            bclk <= 1'b0;
        end else if (tc) begin
            cnt  <= '0;
            bclk <= !bclk;
        end else begin
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2s_dac_tx.sv
// rtl/i2s_dac_tx.sv - I2S master transmitter for the WM8731 DAC path
module i2s_dac_tx
    import audio_pkg::*;
#(
    parameter int DATA_W    = AUD_DATA_W,
    parameter int SLOT_W    = AUD_SLOT_W,
    parameter int BCLK_HALF = AUD_BCLK_HALF
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              enable,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_left,
    input  logic [DATA_W-1:0] s_right,
    output logic              s_ready,
    output logic              aud_bclk,
    output logic              aud_daclrck,
    output logic              aud_dacdat,
    output logic              frame_start,
    output logic              underrun
);
    localparam int FRAME_W = 2 * SLOT_W;
    localparam int KW      = $clog2(FRAME_W);

    logic               fall_evt;
    logic [KW-1:0]      k;
    logic [KW-1:0]      k_next;
    logic               active;
    logic               load;
    logic               accept;
    logic               buf_full;
    logic               buf_full_next;
    logic [DATA_W-1:0]  buf_left;
    logic [DATA_W-1:0]  buf_right;
    logic [FRAME_W-1:0] sreg;
    logic [FRAME_W-1:0] frame;

    i2s_bclk_gen #(
        .BCLK_HALF (BCLK_HALF)
    ) u_bclk (
        .clk      (clk_clk),
        .resetn   (reset_reset_n),
        .enable   (enable),
        .bclk     (aud_bclk),
        .fall_evt (fall_evt)
    );

    // Frame boundary, next bit index, buffer occupancy and the frame image to load.
    always_comb begin
        accept        = s_valid && s_ready;
        // The first fall after enabling starts a frame just like the wrap does.
        load          = fall_evt && (!active || (k == KW'(FRAME_W - 1)));
        k_next        = load ? '0 : k + 1'b1;
        buf_full_next = buf_full;
        if (load && buf_full) begin
            buf_full_next = 1'b0;
        end
        if (accept) begin
            buf_full_next = 1'b1;
        end
        // Bit FRAME_W-1-k is sent in period k; the zero above each word is the
        // I2S one-bit delay. A pair accepted in this clk is not yet in buf_full.
        frame = '0;
        if (buf_full) begin
            frame[FRAME_W-2 -: DATA_W] = buf_left;
            frame[SLOT_W-2 -: DATA_W]  = buf_right;
        end
    end

    // One-pair holding buffer; s_ready stays low for one clk after a load from full.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            buf_full  <= 1'b0;
            buf_left  <= '0;
            buf_right <= '0;
            s_ready   <= 1'b0;
        end else begin
            buf_full <= buf_full_next;
            if (accept) begin
                buf_left  <= s_left;
                buf_right <= s_right;
            end
            s_ready <= !buf_full_next && !(load && buf_full);
        end
    end

    // Bit index, word clock and serial data, all updated on the BCLK fall.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            k           <= '0;
            active      <= 1'b0;
            sreg        <= '0;
            aud_daclrck <= LRCK_LEFT;
            aud_dacdat  <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            if (!enable) begin
                k           <= '0;
                active      <= 1'b0;
                sreg        <= '0;
                aud_daclrck <= LRCK_LEFT;
                aud_dacdat  <= 1'b0;
            end else if (fall_evt) begin
                k           <= k_next;
                active      <= 1'b1;
                aud_daclrck <= (k_next >= KW'(SLOT_W)) ? LRCK_RIGHT : LRCK_LEFT;
                if (load) begin
                    aud_dacdat  <= frame[FRAME_W-1];
                    sreg        <= frame << 1;
                    frame_start <= 1'b1;
                    underrun    <= !buf_full;
                end else begin
                    aud_dacdat  <= sreg[FRAME_W-1];
                    sreg        <= sreg << 1;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// tb/tb_i2s_dac_tx.sv - directed self-checking bench for i2s_dac_tx
module tb_i2s_dac_tx;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        enable = 1'b0;
    logic        s_valid = 1'b0;
    logic [23:0] s_left = '0;
    logic [23:0] s_right = '0;
    logic        s_ready;
    logic        aud_bclk;
    logic        aud_daclrck;
    logic        aud_dacdat;
    logic        frame_start;
    logic        underrun;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] cap_dat;
    logic [63:0] cap_lrck;

    always #5 clk = ~clk;

    i2s_dac_tx dut (
        .clk_clk       (clk),
        .reset_reset_n (resetn),
        .enable        (enable),
        .s_valid       (s_valid),
        .s_left        (s_left),
        .s_right       (s_right),
        .s_ready       (s_ready),
        .aud_bclk      (aud_bclk),
        .aud_daclrck   (aud_daclrck),
        .aud_dacdat    (aud_dacdat),
        .frame_start   (frame_start),
        .underrun      (underrun)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic wait_fs(input string tag, input int budget);
        int n;
        n = 0;
        while (frame_start !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check(tag, 64'(frame_start), 64'd1);
    endtask

    task automatic push(input string tag, input logic [23:0] l, input logic [23:0] r);
        logic rd;
        int   n;
        n = 0;
        s_left  = l;
        s_right = r;
        s_valid = 1'b1;
        do begin
            rd = s_ready;
            tick();
            n++;
        end while (!rd && n < 2048);
        s_valid = 1'b0;
        check(tag, 64'(rd), 64'd1);
    endtask

    // Samples each of the 64 periods right after its BCLK fall; bit 63-k holds period k.
    task automatic capture();
        for (int kk = 0; kk < 64; kk++) begin
            cap_dat[63-kk]  = aud_dacdat;
            cap_lrck[63-kk] = aud_daclrck;
            tick(16);
        end
    endtask

    function automatic logic [63:0] exp_frame(input logic [23:0] l, input logic [23:0] r);
        logic [63:0] f;
        f = '0;
        for (int kk = 1; kk <= 24; kk++) f[63-kk] = l[24-kk];
        for (int kk = 33; kk <= 56; kk++) f[63-kk] = r[24-(kk-32)];
        return f;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int nfs;
        int acc;
        int urs;
        int rdlow;
        int rdrise;
        logic prev_fs;

        // Reset, then free-running with no input
        tick(2);
        check("rst_outs", 64'({aud_bclk, aud_daclrck, aud_dacdat, frame_start, underrun, s_ready}), 64'd0);
        resetn = 1'b1;
        tick();
        check("rdy_after_release", 64'(s_ready), 64'd1);
        enable = 1'b1;
        tick(7);
        check("bclk_before_rise", 64'(aud_bclk), 64'd0);
        tick();
        check("bclk_rise_clk8", 64'(aud_bclk), 64'd1);
        tick(7);
        check("fs_before_fall", 64'(frame_start), 64'd0);
        tick();
        check("first_fs_clk16", 64'({aud_bclk, frame_start, underrun, aud_dacdat, aud_daclrck}), 64'b01100);
        capture();
        check("idle_dat", cap_dat, 64'd0);
        check("idle_lrck", cap_lrck, 64'h0000_0000_FFFF_FFFF);
        check("idle_second_underrun", 64'({frame_start, underrun}), 64'b11);

        // Pair buffered before the first load
        enable = 1'b0;
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        push("t2_push", 24'h800001, 24'h7FFFFE);
        check("t2_ready_full", 64'(s_ready), 64'd0);
        enable = 1'b1;
        wait_fs("t2_fs", 40);
        check("t2_no_underrun", 64'(underrun), 64'd0);
        capture();
        check("t2_dat", cap_dat, 64'h4000_0080_3FFF_FF00);
        check("t2_lrck", cap_lrck, 64'h0000_0000_FFFF_FFFF);

        // Streaming with s_valid held high
        s_left  = 24'h000100;
        s_right = 24'hFFFF00;
        s_valid = 1'b1;
        tick();
        wait_fs("t3_fs", 1100);
        nfs = 0; acc = 0; urs = 0; rdlow = 0; rdrise = 0; prev_fs = 1'b0;
        for (int i = 0; i < 3072; i++) begin
            if (s_ready) acc++;
            if (underrun) urs++;
            if (frame_start) begin
                nfs++;
                if (!s_ready) rdlow++;
            end
            if (prev_fs && s_ready) rdrise++;
            prev_fs = frame_start;
            tick();
        end
        s_valid = 1'b0;
        check("t3_frames", 64'(nfs), 64'd3);
        check("t3_accepts", 64'(acc), 64'd3);
        check("t3_underruns", 64'(urs), 64'd0);
        check("t3_ready_low_at_fs", 64'(rdlow), 64'd3);
        check("t3_ready_rise_after_fs", 64'(rdrise), 64'd3);
        check("t3_at_fs", 64'(frame_start), 64'd1);

        // s_valid raised in the exact clk of an empty-buffer load
        tick(1023);
        s_left  = 24'hC00003;
        s_right = 24'h000001;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        check("t4_coincide", 64'({frame_start, underrun, s_ready}), 64'b110);
        capture();
        check("t4_empty_frame", cap_dat, 64'd0);
        check("t4_next_no_underrun", 64'({frame_start, underrun}), 64'b10);
        capture();
        check("t4_pair_frame", cap_dat, exp_frame(24'hC00003, 24'h000001));

        // Disable mid-frame at k=40 with a pair buffered
        push("t5_push_a", 24'h5A5A5A, 24'hFF0001);
        wait_fs("t5_fs_a", 1100);
        s_left  = 24'h0F0F0F;
        s_right = 24'h3C3C3C;
        s_valid = 1'b1;
        tick(2);
        s_valid = 1'b0;
        check("t5_buffer_full", 64'(s_ready), 64'd0);
        tick(646);
        check("t5_k40_live", 64'({aud_bclk, aud_daclrck, aud_dacdat}), 64'b111);
        enable = 1'b0;
        tick();
        check("t5_disabled", 64'({aud_bclk, aud_daclrck, aud_dacdat, s_ready}), 64'd0);
        tick(5);
        check("t5_still_idle", 64'({aud_bclk, aud_daclrck, aud_dacdat, frame_start, s_ready}), 64'd0);
        enable = 1'b1;
        wait_fs("t5_fs_re", 40);
        check("t5_no_underrun", 64'(underrun), 64'd0);
        capture();
        check("t5_pair_frame", cap_dat, exp_frame(24'h0F0F0F, 24'h3C3C3C));

        // Reset pulse at k=10
        push("t6_push", 24'h111111, 24'h222222);
        tick(167);
        check("t6_k10_live", 64'({aud_bclk, s_ready}), 64'b10);
        resetn = 1'b0;
        tick();
        check("t6_reset_outs", 64'({aud_bclk, aud_daclrck, aud_dacdat, frame_start, underrun, s_ready}), 64'd0);
        resetn = 1'b1;
        tick();
        check("t6_ready_release", 64'(s_ready), 64'd1);
        tick(15);
        check("t6_restart_underrun", 64'({frame_start, underrun}), 64'b11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
